// File: rtl/mips_pkg.sv
// Shared MIPS datapath encodings and defaults: PC source select, branch
// condition codes, reset/exception vectors and the branch-target helper.
package mips_pkg;

    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_BR  = 2'b01,
        PC_J   = 2'b10,
        PC_JR  = 2'b11
    } pc_sel_t;

    typedef enum logic [2:0] {
        BR_BEQ    = 3'b000,
        BR_BNE    = 3'b001,
        BR_BLEZ   = 3'b010,
        BR_BGTZ   = 3'b011,
        BR_BLTZ   = 3'b100,
        BR_BGEZ   = 3'b101,
        BR_BLTZAL = 3'b110,
        BR_BGEZAL = 3'b111
    } br_op_t;

    typedef enum logic {
        PEND_IDLE = 1'b0,
        PEND_WAIT = 1'b1
    } pend_state_t;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;

    // Word offset is sign-extended and scaled; wrap-around is intentional.
    function automatic logic [31:0] br_target(input logic [31:0] pc_4,
                                              input logic [15:0] off);
        return pc_4 + {{14{off[15]}}, off, 2'b00};
    endfunction

endpackage

// File: rtl/pc_unit_br_cond.sv
// Branch condition decode: whether the condition named by br_op holds and
// whether the opcode is one of the linking forms.
module br_cond
    import mips_pkg::*;
(
    input  logic [2:0] br_op,
    input  logic       zero,
    input  logic       rs_neg,
    input  logic       rs_zero,
    output logic       cond,
    output logic       link
);

    always_comb begin
        cond = 1'b0;
        case (br_op)
            BR_BEQ:    cond = zero;
            BR_BNE:    cond = !zero;
            BR_BLEZ:   cond = rs_neg | rs_zero;
            BR_BGTZ:   cond = !rs_neg & !rs_zero;
            BR_BLTZ:   cond = rs_neg;
            BR_BGEZ:   cond = !rs_neg;
            BR_BLTZAL: cond = rs_neg;
            BR_BGEZAL: cond = !rs_neg;
            default:   cond = 1'b0;
        endcase
    end

    assign link = (br_op[2:1] == 2'b11);

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: architectural PC, EPC and a one-deep latch for
// redirects that arrive while fetch is stalled.
module pc_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
    parameter logic [31:0] EXC_VEC     = DEF_EXC_VEC,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  pc_sel,
    input  logic [2:0]  br_op,
    input  logic        zero,
    input  logic        rs_neg,
    input  logic        rs_zero,
    input  logic [25:0] imm26,
    input  logic [31:0] gpr,
    input  logic        exc_req,
    input  logic        eret,
    output logic [31:0] pc,
    output logic [31:0] pc_4,
    output logic [31:0] npc,
    output logic        link_we,
    output logic [31:0] epc,
    output logic        redirect_pend,
    output logic        addr_err
);

    logic [31:0] pc_q;
    logic [31:0] epc_q;
    logic [31:0] pend_pc;
    pend_state_t pend_st;

    logic cond;
    logic link_op;
    logic taken;
    logic redirect;

    br_cond u_br_cond (
        .br_op   (br_op),
        .zero    (zero),
        .rs_neg  (rs_neg),
        .rs_zero (rs_zero),
        .cond    (cond),
        .link    (link_op)
    );

    assign pc_4  = pc_q + 32'd4;
    assign taken = (pc_sel == PC_BR) && cond;

    always_comb begin
        npc = pc_4;
        case (pc_sel)
            PC_BR:   npc = taken ? br_target(pc_4, imm26[15:0]) : pc_4;
            PC_J:    npc = {pc_4[31:28], imm26, 2'b00};
            PC_JR:   npc = gpr;
            default: npc = pc_4;
        endcase
    end

    // A jump/jr that happens to land on pc+4 is not worth latching.
    assign redirect = (pc_sel != PC_SEQ) && (npc != pc_4);

    assign link_we  = taken && link_op && !stall;
    assign addr_err = CHECK_ALIGN && (pc_sel == PC_JR) && (|gpr[1:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            epc_q   <= 32'd0;
            pend_pc <= 32'd0;
            pend_st <= PEND_IDLE;
        end else if (exc_req) begin
            epc_q   <= pc_q;
            pc_q    <= EXC_VEC;
            pend_st <= PEND_IDLE;
        end else if (eret && !stall) begin
            pc_q    <= epc_q;
            pend_st <= PEND_IDLE;
        end else if (stall) begin
            // First redirect seen during a stall wins; later ones are dropped.
            if (pend_st == PEND_IDLE && redirect) begin
                pend_pc <= npc;
                pend_st <= PEND_WAIT;
            end
        end else if (pend_st == PEND_WAIT) begin
            pc_q    <= pend_pc;
            pend_st <= PEND_IDLE;
        end else begin
            pc_q <= npc;
        end
    end

    assign pc            = pc_q;
    assign epc           = epc_q;
    assign redirect_pend = (pend_st == PEND_WAIT);

endmodule
